dac_spi_tx: RTL and testbench
=============================

DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 Parameter SHALL be: CLK_DIV, 4, sclk half-period in clk cycles (legal range 1..255).
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  one-cycle request to transmit one frame.
REQ-006 data_in  input  12  DAC code, unsigned.
REQ-007 pd_mode  input  2  DAC power-down bits (00 = normal operation).
REQ-008 sclk  output  1  serial clock to DAC, idle high.
REQ-009 sync_n  output  1  active-low frame select.
REQ-010 sdata  output  1  serial data, MSB first.
REQ-011 busy  output  1  high while a frame or hold interval is in progress.
REQ-012 done  output  1  one-cycle pulse at frame completion.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and HOLD.
REQ-014 Frame word SHALL be 16 bits: {2'b00, pd_mode, data_in[11:0]}, sent bit 15 first.
REQ-015 The word SHALL be latched only in the cycle start is accepted; later data_in/pd_mode changes SHALL NOT affect the frame in flight.
REQ-016 IDLE: sync_n=1, sclk=1, sdata=0, busy=0.
REQ-017 start=1 in IDLE SHALL be accepted; on the next cycle the FSM SHALL be in SHIFT with sync_n=0, sclk=1, sdata=bit 15, busy=1.
REQ-018 In SHIFT, each bit SHALL occupy 2*CLK_DIV cycles: CLK_DIV cycles with sclk=1, then CLK_DIV cycles with sclk=0.
REQ-019 sdata SHALL change only together with a sclk rising transition (or at SHIFT entry) and SHALL be stable across every sclk falling edge (DAC samples on falling edge).
REQ-020 Exactly 16 sclk falling edges SHALL occur per frame; sync_n SHALL be low for exactly 32*CLK_DIV cycles.
REQ-021 After the 16th low half-period, the FSM SHALL enter HOLD: sync_n=1, sclk=1, sdata=0, busy=1, for CLK_DIV cycles.
REQ-022 On leaving HOLD, the FSM SHALL return to IDLE and done SHALL be 1 for exactly that first IDLE cycle.
REQ-023 Latency: start accepted at cycle N gives sync_n low over N+1..N+32*CLK_DIV, HOLD over the next CLK_DIV cycles, and done at N+33*CLK_DIV+1.
REQ-024 start while busy=1 SHALL be ignored (not queued).
REQ-025 start in the same cycle as done (IDLE) SHALL be accepted; back-to-back frames SHALL therefore be separated by CLK_DIV+1 cycles of sync_n=1.
REQ-026 The half-period counter and the bit counter (0..15) SHALL NOT wrap into an extra bit; bit counter exhaustion SHALL force the HOLD transition.
REQ-027 CLK_DIV=1 SHALL be supported: sclk=clk/2 and HOLD lasts one cycle.
REQ-028 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-029 While rst=1, outputs SHALL be sclk=1, sync_n=1, sdata=0, busy=0, done=0, with the FSM in IDLE and counters and shift register cleared.
REQ-030 Reset asserted mid-frame SHALL abort immediately (asynchronously); the partial frame SHALL NOT resume, no done SHALL be produced, and the first start after release SHALL transmit a full new frame.
REQ-031 start sampled in the first cycle after rst deassertion SHALL be accepted normally.

Verification
REQ-032 CLK_DIV=4, data_in=0xABC, pd_mode=00, start pulse -> falling-edge samples 0000_1010_1011_1100, sync_n low 128 cycles, 16 falling edges, done 133 cycles after start.
REQ-033 start pulsed again 10 and 100 cycles after the first accept, with data_in=0x123 -> ignored; the frame still carries 0xABC and only one done pulse occurs.
REQ-034 start held high continuously with data_in=0xFFF then 0x000 -> frames back-to-back, sync_n high for exactly 5 cycles between them, words 0x0FFF and 0x0000.
REQ-035 rst asserted at cycle 60 of a frame -> same-cycle sclk=1, sync_n=1, busy=0, no done; next frame 0x555 transmits completely.
REQ-036 CLK_DIV=1, data_in=0x800, pd_mode=11 -> word 0x3800, sync_n low 32 cycles, HOLD 1 cycle, done at start+34.
REQ-037 data_in changed every cycle during a frame -> transmitted word equals the value latched at accept.

Source files
------------

// File: rtl/dac_spi_tx.sv
// Serial transmitter for a 16-bit DAC frame {2'b00, pd_mode, data_in}, MSB first.
// sclk idles high, and the DAC samples sdata on the falling edges of sclk.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] data_in,
  input  logic [1:0]  pd_mode,
  output logic        sclk,
  output logic        sync_n,
  output logic        sdata,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t      state, stateNext;
  logic [7:0]  halfCnt, halfCntNext;
  logic [3:0]  bitCnt, bitCntNext;
  logic [15:0] shiftReg, shiftRegNext;
  logic        sclkNext, syncNext, sdataNext, busyNext, doneNext;
  logic        halfEnd;

  assign halfEnd = (halfCnt == HALF_LAST);

  // Outputs are computed one cycle ahead and registered, so every output is a flop.
  always_comb begin
    stateNext    = state;
    halfCntNext  = halfCnt;
    bitCntNext   = bitCnt;
    shiftRegNext = shiftReg;
    sclkNext     = sclk;
    syncNext     = sync_n;
    sdataNext    = sdata;
    busyNext     = busy;
    doneNext     = 1'b0;

    case (state)
      IDLE: begin
        sclkNext    = 1'b1;
        syncNext    = 1'b1;
        sdataNext   = 1'b0;
        busyNext    = 1'b0;
        halfCntNext = '0;
        bitCntNext  = '0;
        if (start) begin
          stateNext    = SHIFT;
          shiftRegNext = {2'b00, pd_mode, data_in};
          sdataNext    = 1'b0;
          syncNext     = 1'b0;
          busyNext     = 1'b1;
        end
      end

      SHIFT: begin
        if (!halfEnd) begin
          halfCntNext = halfCnt + 8'd1;
        end else begin
          halfCntNext = '0;
          if (sclk) begin
            sclkNext = 1'b0;
          end else if (bitCnt == 4'd15) begin
            // Last low half-period done: bit counter exhaustion ends the frame.
            stateNext    = HOLD;
            sclkNext     = 1'b1;
            syncNext     = 1'b1;
            sdataNext    = 1'b0;
            shiftRegNext = '0;
          end else begin
            bitCntNext   = bitCnt + 4'd1;
            shiftRegNext = {shiftReg[14:0], 1'b0};
            sdataNext    = shiftReg[14];
            sclkNext     = 1'b1;
          end
        end
      end

      HOLD: begin
        if (!halfEnd) begin
          halfCntNext = halfCnt + 8'd1;
        end else begin
          stateNext   = IDLE;
          halfCntNext = '0;
          bitCntNext  = '0;
          busyNext    = 1'b0;
          doneNext    = 1'b1;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      halfCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      sclk     <= 1'b1;
      sync_n   <= 1'b1;
      sdata    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= stateNext;
      halfCnt  <= halfCntNext;
      bitCnt   <= bitCntNext;
      shiftReg <= shiftRegNext;
      sclk     <= sclkNext;
      sync_n   <= syncNext;
      sdata    <= sdataNext;
      busy     <= busyNext;
      done     <= doneNext;
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: one instance with CLK_DIV=4, one with CLK_DIV=1.
// A monitor decodes frames from the serial pins; tasks push expected words and compare.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start1;
  logic [11:0] data4, data1;
  logic [1:0]  pd4, pd1;
  logic        sclk4, sync4, sdata4, busy4, done4;
  logic        sclk1, sync1, sdata1, busy1, done1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_spi_tx #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .data_in(data4), .pd_mode(pd4),
    .sclk(sclk4), .sync_n(sync4), .sdata(sdata4), .busy(busy4), .done(done4)
  );

  dac_spi_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data1), .pd_mode(pd1),
    .sclk(sclk1), .sync_n(sync1), .sdata(sdata1), .busy(busy1), .done(done1)
  );

  typedef struct {
    int          inst;
    logic [15:0] word;
    int          falls;
    int          low;
    int          gap;
  } rx_t;

  typedef struct {
    int          inst;
    logic [15:0] word;
  } exp_t;

  rx_t  rxQ[$];
  exp_t expQ[$];

  logic        inF[2]       = '{1'b0, 1'b0};
  logic        prevSclk[2]  = '{1'b1, 1'b1};
  logic        prevSdata[2] = '{1'b0, 1'b0};
  logic [15:0] bits[2]      = '{16'h0, 16'h0};
  int          falls[2]     = '{0, 0};
  int          low[2]       = '{0, 0};
  int          highRun[2]   = '{0, 0};
  int          gapAt[2]     = '{0, 0};
  int          doneCnt[2]   = '{0, 0};
  int          doneCyc[2]   = '{0, 0};
  int          viol[2]      = '{0, 0};

  // Frame decoder: sample sdata on every sclk falling edge while sync_n is low.
  always @(negedge clk) begin
    logic sc[2];
    logic sn[2];
    logic sd[2];
    logic dn[2];
    sc[0] = sclk4; sn[0] = sync4; sd[0] = sdata4; dn[0] = done4;
    sc[1] = sclk1; sn[1] = sync1; sd[1] = sdata1; dn[1] = done1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        inF[i] = 1'b0; prevSclk[i] = 1'b1; prevSdata[i] = 1'b0;
        bits[i] = '0; falls[i] = 0; low[i] = 0; highRun[i] = 0;
      end else begin
        if (!sn[i]) begin
          if (!inF[i]) begin
            inF[i] = 1'b1; gapAt[i] = highRun[i];
            bits[i] = '0; falls[i] = 0; low[i] = 0;
          end else if (sd[i] !== prevSdata[i] && !(sc[i] && !prevSclk[i])) begin
            viol[i]++;
          end
          low[i]++;
          if (prevSclk[i] && !sc[i]) begin
            bits[i] = {bits[i][14:0], sd[i]};
            falls[i]++;
          end
        end else begin
          if (inF[i]) begin
            rxQ.push_back('{i, bits[i], falls[i], low[i], gapAt[i]});
            inF[i] = 1'b0;
            highRun[i] = 0;
          end
          highRun[i]++;
        end
        if (dn[i]) begin
          doneCnt[i]++;
          doneCyc[i] = cyc;
        end
        prevSclk[i]  = sc[i];
        prevSdata[i] = sd[i];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic waitRx(input int n, input int budget, output bit ok);
    int t = 0;
    while (rxQ.size() < n && t < budget) begin
      tick();
      t++;
    end
    ok = (rxQ.size() >= n);
  endtask

  task automatic waitDone(input int inst, input int prev, input int budget, output bit ok);
    int t = 0;
    while (doneCnt[inst] == prev && t < budget) begin
      tick();
      t++;
    end
    ok = (doneCnt[inst] != prev);
  endtask

  task automatic popFrame(output rx_t r, output exp_t e);
    r = rxQ.pop_front();
    e = expQ.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start4 = 1'b0; start1 = 1'b0;
    data4 = '0; data1 = '0; pd4 = '0; pd1 = '0;
    tick(); tick();
    checks++; if (sclk4 !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b want 1", sclk4); end
    checks++; if (sync4 !== 1'b1) begin errors++; $display("FAIL reset_sync_n: got %b want 1", sync4); end
    checks++; if (sdata4 !== 1'b0) begin errors++; $display("FAIL reset_sdata: got %b want 0", sdata4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done4); end
    checks++;
    if ({sclk1, sync1, sdata1, busy1, done1} !== 5'b11000) begin
      errors++; $display("FAIL reset_div1: got %b want 11000", {sclk1, sync1, sdata1, busy1, done1});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_and_ignore();
    int t0, d0;
    bit ok;
    rx_t r;
    exp_t e;
    data4 = 12'hABC; pd4 = 2'b00; start4 = 1'b1;
    expQ.push_back('{0, 16'h0ABC});
    t0 = cyc; d0 = doneCnt[0];
    tick();
    start4 = 1'b0;
    checks++;
    if ({sync4, sclk4, sdata4, busy4} !== 4'b0101) begin
      errors++; $display("FAIL shift_entry: got %b want 0101", {sync4, sclk4, sdata4, busy4});
    end
    for (int k = 1; k <= 200; k++) begin
      start4 = (k == 9 || k == 99);
      if (start4) data4 = 12'h123;
      tick();
    end
    start4 = 1'b0;
    checks++; if (doneCnt[0] - d0 !== 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", doneCnt[0] - d0); end
    checks++; if (doneCyc[0] - t0 !== 133) begin errors++; $display("FAIL single_latency: got %0d want 133", doneCyc[0] - t0); end
    waitRx(1, 10, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_frame_timeout: got 0 frames want 1");
    end else begin
      checks++; if (rxQ.size() !== 1) begin errors++; $display("FAIL single_extra_frames: got %0d want 1", rxQ.size()); end
      popFrame(r, e);
      checks++; if (r.word !== e.word) begin errors++; $display("FAIL single_word: got %h want %h", r.word, e.word); end
      checks++; if (r.falls !== 16) begin errors++; $display("FAIL single_falls: got %0d want 16", r.falls); end
      checks++; if (r.low !== 128) begin errors++; $display("FAIL single_sync_low: got %0d want 128", r.low); end
      rxQ.delete();
    end
    checks++; if (viol[0] !== 0) begin errors++; $display("FAIL single_sdata_stable: got %0d changes want 0", viol[0]); end
  endtask

  task automatic test_back_to_back();
    int d0;
    bit ok;
    rx_t r;
    exp_t e;
    data4 = 12'hFFF; pd4 = 2'b00; start4 = 1'b1;
    expQ.push_back('{0, 16'h0FFF});
    d0 = doneCnt[0];
    tick();
    data4 = 12'h000;
    expQ.push_back('{0, 16'h0000});
    waitDone(0, d0, 300, ok);
    tick();
    start4 = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout: got no done want 1"); end
    waitRx(2, 300, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_frame_timeout: got %0d frames want 2", rxQ.size());
    end else begin
      popFrame(r, e);
      checks++; if (r.word !== e.word) begin errors++; $display("FAIL b2b_word1: got %h want %h", r.word, e.word); end
      popFrame(r, e);
      checks++; if (r.word !== e.word) begin errors++; $display("FAIL b2b_word2: got %h want %h", r.word, e.word); end
      checks++; if (r.gap !== 5) begin errors++; $display("FAIL b2b_gap: got %0d want 5", r.gap); end
      checks++; if (r.falls !== 16) begin errors++; $display("FAIL b2b_falls2: got %0d want 16", r.falls); end
    end
    repeat (20) tick();
  endtask

  task automatic test_reset_abort();
    int d0;
    bit ok;
    rx_t r;
    exp_t e;
    data4 = 12'h0AA; pd4 = 2'b01; start4 = 1'b1;
    d0 = doneCnt[0];
    tick();
    start4 = 1'b0;
    repeat (61) tick();
    checks++; if (sclk4 !== 1'b0) begin errors++; $display("FAIL abort_pre_sclk: got %b want 0", sclk4); end
    rst = 1'b1;
    #1;
    checks++;
    if ({sclk4, sync4, busy4, sdata4} !== 4'b1100) begin
      errors++; $display("FAIL abort_outputs: got %b want 1100", {sclk4, sync4, busy4, sdata4});
    end
    repeat (3) tick();
    rst = 1'b0;
    data4 = 12'h555; pd4 = 2'b00; start4 = 1'b1;
    expQ.push_back('{0, 16'h0555});
    tick();
    start4 = 1'b0;
    waitDone(0, d0, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_done_timeout: got no done want 1"); end
    tick();
    checks++; if (doneCnt[0] - d0 !== 1) begin errors++; $display("FAIL abort_done_count: got %0d want 1", doneCnt[0] - d0); end
    checks++;
    if (rxQ.size() !== 1) begin
      errors++; $display("FAIL abort_frames: got %0d want 1", rxQ.size());
    end else begin
      popFrame(r, e);
      checks++; if (r.word !== e.word) begin errors++; $display("FAIL abort_next_word: got %h want %h", r.word, e.word); end
      checks++; if (r.low !== 128) begin errors++; $display("FAIL abort_next_low: got %0d want 128", r.low); end
    end
    rxQ.delete();
  endtask

  task automatic test_clkdiv1();
    int t0, d0;
    bit ok;
    rx_t r;
    exp_t e;
    data1 = 12'h800; pd1 = 2'b11; start1 = 1'b1;
    expQ.push_back('{1, 16'h3800});
    t0 = cyc; d0 = doneCnt[1];
    tick();
    start1 = 1'b0;
    waitDone(1, d0, 100, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL div1_done_timeout: got no done want 1");
    end else begin
      checks++; if (doneCyc[1] - t0 !== 34) begin errors++; $display("FAIL div1_latency: got %0d want 34", doneCyc[1] - t0); end
    end
    waitRx(1, 10, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL div1_frame_timeout: got 0 frames want 1");
    end else begin
      popFrame(r, e);
      checks++; if (r.inst !== 1 || r.word !== e.word) begin errors++; $display("FAIL div1_word: got %h want %h", r.word, e.word); end
      checks++; if (r.falls !== 16) begin errors++; $display("FAIL div1_falls: got %0d want 16", r.falls); end
      checks++; if (r.low !== 32) begin errors++; $display("FAIL div1_sync_low: got %0d want 32", r.low); end
    end
    checks++; if (viol[1] !== 0) begin errors++; $display("FAIL div1_sdata_stable: got %0d changes want 0", viol[1]); end
  endtask

  task automatic test_data_churn();
    int d0;
    bit ok;
    rx_t r;
    exp_t e;
    for (int n = 0; n < 2; n++) begin
      data4 = 12'($urandom); pd4 = 2'($urandom); start4 = 1'b1;
      expQ.push_back('{0, {2'b00, pd4, data4}});
      d0 = doneCnt[0];
      tick();
      start4 = 1'b0;
      for (int k = 0; k < 200 && doneCnt[0] == d0; k++) begin
        data4 = 12'($urandom); pd4 = 2'($urandom);
        tick();
      end
      checks++; if (doneCnt[0] == d0) begin errors++; $display("FAIL churn_done_timeout: got no done want 1"); end
      waitRx(1, 10, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL churn_frame_timeout: got 0 frames want 1");
      end else begin
        popFrame(r, e);
        checks++; if (r.word !== e.word) begin errors++; $display("FAIL churn_word: got %h want %h", r.word, e.word); end
      end
      tick();
    end
    checks++; if (viol[0] !== 0) begin errors++; $display("FAIL churn_sdata_stable: got %0d changes want 0", viol[0]); end
  endtask

  initial begin
    test_reset();
    test_single_and_ignore();
    test_back_to_back();
    test_reset_abort();
    test_clkdiv1();
    test_data_churn();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
